lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/rv_pkg.sv | 25 ++
 rtl/lsu_align.sv | 70 +++++++
 rtl/lsu.sv | 145 ++++++++++++++
 tb/tb_lsu.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_pkg.sv
// Shared RV core definitions: load/store size encodings, LSU FSM states, bus timeout default.
package rv_pkg;

  localparam int unsigned XLEN            = 32;
  localparam int unsigned MEM_TIMEOUT_DEF = 255;

  // funct3[1:0] access size; funct3[2] selects zero-extension on loads
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam int unsigned F3_UNSIGNED = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUS  = 2'd1,
    ST_DONE = 2'd2
  } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for stores and load extraction/extension. Misaligned H/W
// accesses are flagged only when LSU_MISALIGN_TRAP_EN is defined.
module lsu_align
  import rv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic            is_store,
  input  logic [1:0]      addr_lo,
  input  logic [XLEN-1:0] wdata,
  input  logic [XLEN-1:0] mem_rdata,
  output logic [3:0]      wstrb_c,
  output logic [XLEN-1:0] wdata_c,
  output logic [XLEN-1:0] rdata_c,
  output logic            misal_c
);

  logic [1:0]      size;
  logic [1:0]      off;
  logic [XLEN-1:0] shifted;

  // Offending low offset bits are dropped: H keeps addr[1], W always offset 0
  always_comb begin
    size = funct3[1:0];
    off  = 2'b00;
    case (size)
      SZ_B:    off = addr_lo;
      SZ_H:    off = {addr_lo[1], 1'b0};
      default: off = 2'b00;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misal_c = ((size == SZ_H) && addr_lo[0]) || (size[1] && (addr_lo != 2'b00));
`else
  assign misal_c = 1'b0;
`endif

  always_comb begin
    wstrb_c = 4'b0000;
    wdata_c = wdata;
    if (is_store) begin
      case (size)
        SZ_B: begin
          wstrb_c = 4'b0001 << off;
          wdata_c = {4{wdata[7:0]}};
        end
        SZ_H: begin
          wstrb_c = 4'b0011 << off;
          wdata_c = {2{wdata[15:0]}};
        end
        default: begin
          wstrb_c = 4'b1111;
          wdata_c = wdata;
        end
      endcase
    end
  end

  always_comb begin
    shifted = mem_rdata >> {off, 3'b000};
    case (size)
      SZ_B:    rdata_c = funct3[F3_UNSIGNED] ? {24'd0, shifted[7:0]}
                                             : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    rdata_c = funct3[F3_UNSIGNED] ? {16'd0, shifted[15:0]}
                                             : {{16{shifted[15]}}, shifted[15:0]};
      default: rdata_c = shifted;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// Load/store unit: IDLE -> BUS -> DONE handshake with bus timeout.
// Optional misaligned-access trap enabled by LSU_MISALIGN_TRAP_EN.
module lsu
  import rv_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = MEM_TIMEOUT_DEF
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            start,
  input  logic            is_store,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] rdata,
  output logic            misalign,
  output logic            bus_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  output logic            mem_rstrb,
  output logic            mem_valid,
  input  logic            mem_ready,
  input  logic [XLEN-1:0] mem_rdata
);

  localparam int unsigned     CNT_W    = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_TIMEOUT - 1);

  lsu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       f3_q;
  logic [1:0]       off_q;
  logic             store_q;

  logic [2:0]       al_f3;
  logic [1:0]       al_off;
  logic             al_store;
  logic [3:0]       wstrb_c;
  logic [XLEN-1:0]  wdata_c;
  logic [XLEN-1:0]  rdata_c;
  logic             misal_c;
  logic             timeout_c;

  // Aligner sees live inputs while accepting, latched request afterwards
  assign al_f3     = (state_q == ST_IDLE) ? funct3 : f3_q;
  assign al_off    = (state_q == ST_IDLE) ? addr[1:0] : off_q;
  assign al_store  = (state_q == ST_IDLE) ? is_store : store_q;
  assign timeout_c = !mem_ready && (cnt_q == CNT_LAST);

  lsu_align u_align (
    .funct3    (al_f3),
    .is_store  (al_store),
    .addr_lo   (al_off),
    .wdata     (wdata),
    .mem_rdata (mem_rdata),
    .wstrb_c   (wstrb_c),
    .wdata_c   (wdata_c),
    .rdata_c   (rdata_c),
    .misal_c   (misal_c)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (start) state_d = misal_c ? ST_DONE : ST_BUS;
      end
      ST_BUS: begin
        if (mem_ready || timeout_c) state_d = ST_DONE;
        else                        cnt_d   = cnt_q + 1'b1;
      end
      ST_DONE: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, request latch and registered outputs
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      f3_q      <= '0;
      off_q     <= '0;
      store_q   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      misalign  <= 1'b0;
      bus_err   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      mem_rstrb <= 1'b0;
      mem_valid <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy    <= (state_d != ST_IDLE);
      done    <= (state_d == ST_DONE);
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            f3_q     <= funct3;
            off_q    <= addr[1:0];
            store_q  <= is_store;
            misalign <= misal_c;
            bus_err  <= 1'b0;
            rdata    <= '0;
            if (!misal_c) begin
              mem_valid <= 1'b1;
              mem_addr  <= {addr[XLEN-1:2], 2'b00};
              mem_wdata <= wdata_c;
              mem_wstrb <= wstrb_c;
              mem_rstrb <= !is_store;
            end
          end
        end
        ST_BUS: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            rdata     <= store_q ? '0 : rdata_c;
          end else if (timeout_c) begin
            mem_valid <= 1'b0;
            bus_err   <= 1'b1;
            rdata     <= '0;
          end
        end
        ST_DONE: begin
          misalign <= 1'b0;
          bus_err  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu; completions are checked against a queue of expected results.
module tb_lsu;

  logic        clk = 1'b0;
  logic        resetn;
  logic        start, start_to, is_store;
  logic [2:0]  funct3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        mem_ready;

  logic        busy, done, misalign, bus_err, mem_rstrb, mem_valid;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [3:0]  mem_wstrb;

  logic        to_busy, to_done, to_misalign, to_bus_err, to_mem_rstrb, to_mem_valid;
  logic [31:0] to_rdata, to_mem_addr, to_mem_wdata;
  logic [3:0]  to_mem_wstrb;

  typedef struct {
    logic [31:0] rdata;
    logic        misalign;
    logic        bus_err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  lsu #(.MEM_TIMEOUT(255)) u_dut (
    .clk(clk), .resetn(resetn), .start(start), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .misalign(misalign), .bus_err(bus_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rstrb(mem_rstrb), .mem_valid(mem_valid),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  lsu #(.MEM_TIMEOUT(4)) u_to (
    .clk(clk), .resetn(resetn), .start(start_to), .is_store(is_store), .funct3(funct3),
    .addr(addr), .wdata(wdata), .busy(to_busy), .done(to_done), .rdata(to_rdata),
    .misalign(to_misalign), .bus_err(to_bus_err), .mem_addr(to_mem_addr),
    .mem_wdata(to_mem_wdata), .mem_wstrb(to_mem_wstrb), .mem_rstrb(to_mem_rstrb),
    .mem_valid(to_mem_valid), .mem_ready(1'b0), .mem_rdata(32'hDEAD_BEEF)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] r, input logic m, input logic b);
    exp_t e;
    e.rdata = r; e.misalign = m; e.bus_err = b;
    exp_q.push_back(e);
  endtask

  task automatic drive(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] wd);
    start = 1'b1; is_store = st; funct3 = f3; addr = a; wdata = wd;
  endtask

  // Scoreboard: every done pulse of the main DUT consumes one expected result
  always @(negedge clk) begin
    if (resetn && done) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $error("FAIL sb_unexpected_done: observed done=1 expected no completion");
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("sb_rdata", rdata, e.rdata);
        chk("sb_misalign", 32'(misalign), 32'(e.misalign));
        chk("sb_bus_err", 32'(bus_err), 32'(e.bus_err));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed no finish expected finish before 100000");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 1'b0; start = 1'b0; start_to = 1'b0; is_store = 1'b0; funct3 = 3'b000;
    addr = '0; wdata = '0; mem_rdata = '0; mem_ready = 1'b0;
    step(); step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    resetn = 1'b1;
    step();

    // SB to top byte lane, zero-wait
    mem_ready = 1'b1;
    drive(1'b1, 3'b000, 32'h0000_1003, 32'hAABB_CCDD);
    push(32'd0, 1'b0, 1'b0);
    step(); start = 1'b0;
    chk("sb_valid_c1", 32'(mem_valid), 32'd1);
    chk("sb_busy_c1", 32'(busy), 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_1000);
    chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
    chk("sb_rstrb", 32'(mem_rstrb), 32'd0);
    chk("sb_done_c1", 32'(done), 32'd0);
    step();
    chk("sb_done_c2", 32'(done), 32'd1);
    chk("sb_valid_c2", 32'(mem_valid), 32'd0);
    step();
    chk("sb_idle_busy", 32'(busy), 32'd0);

    // LH / LHU / LB / LBU extraction from 0x8001_1234
    mem_rdata = 32'h8001_1234;
    drive(1'b0, 3'b001, 32'h0000_2002, 32'h0);
    push(32'hFFFF_8001, 1'b0, 1'b0);
    step(); start = 1'b0;
    chk("lh_addr", mem_addr, 32'h0000_2000);
    chk("lh_wstrb", 32'(mem_wstrb), 32'h0);
    chk("lh_rstrb", 32'(mem_rstrb), 32'd1);
    step(); chk("lh_done", 32'(done), 32'd1);
    step();
    drive(1'b0, 3'b101, 32'h0000_2002, 32'h0);
    push(32'h0000_8001, 1'b0, 1'b0);
    step(); start = 1'b0; step(); step();
    drive(1'b0, 3'b000, 32'h0000_2003, 32'h0);
    push(32'hFFFF_FF80, 1'b0, 1'b0);
    step(); start = 1'b0; step(); step();
    drive(1'b0, 3'b100, 32'h0000_2001, 32'h0);
    push(32'h0000_0012, 1'b0, 1'b0);
    step(); start = 1'b0; step(); step();

    // SH upper half; funct3[2] ignored on stores
    drive(1'b1, 3'b101, 32'h0000_0012, 32'h1234_CCDD);
    push(32'd0, 1'b0, 1'b0);
    step(); start = 1'b0;
    chk("sh_wstrb", 32'(mem_wstrb), 32'hC);
    chk("sh_wdata", mem_wdata, 32'hCCDD_CCDD);
    step(); step();

    // LW with ready delayed 5 cycles; a start while busy must be ignored
    mem_ready = 1'b0;
    mem_rdata = 32'hCAFE_F00D;
    drive(1'b0, 3'b010, 32'h0000_4008, 32'h0);
    push(32'hCAFE_F00D, 1'b0, 1'b0);
    step(); start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("lw_wait_valid", 32'(mem_valid), 32'd1);
      chk("lw_wait_addr", mem_addr, 32'h0000_4008);
      chk("lw_wait_done", 32'(done), 32'd0);
      if (i == 1) drive(1'b1, 3'b000, 32'h0000_5000, 32'h0);
      if (i == 2) start = 1'b0;
      if (i == 4) mem_ready = 1'b1;
      step();
    end
    chk("lw_done", 32'(done), 32'd1);
    chk("lw_valid_drop", 32'(mem_valid), 32'd0);

    // start raised during DONE is taken only on the following IDLE cycle
    drive(1'b1, 3'b010, 32'h0000_6000, 32'h0102_0304);
    push(32'd0, 1'b0, 1'b0);
    step();
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("b2b_idle_valid", 32'(mem_valid), 32'd0);
    step(); start = 1'b0;
    chk("b2b_valid", 32'(mem_valid), 32'd1);
    chk("b2b_wstrb", 32'(mem_wstrb), 32'hF);
    chk("b2b_wdata", mem_wdata, 32'h0102_0304);
    step(); step();

    // Misaligned LW
    mem_rdata = 32'h1122_3344;
    drive(1'b0, 3'b010, 32'h0000_3001, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
    push(32'd0, 1'b1, 1'b0);
    step(); start = 1'b0;
    chk("mis_done_c1", 32'(done), 32'd1);
    chk("mis_valid", 32'(mem_valid), 32'd0);
    chk("mis_flag", 32'(misalign), 32'd1);
    step();
`else
    push(32'h1122_3344, 1'b0, 1'b0);
    step(); start = 1'b0;
    chk("mis_valid", 32'(mem_valid), 32'd1);
    chk("mis_addr", mem_addr, 32'h0000_3000);
    step(); chk("mis_done_c2", 32'(done), 32'd1);
    step();
`endif

    // Timeout on the MEM_TIMEOUT=4 instance
    funct3 = 3'b010; addr = 32'h0000_7000; is_store = 1'b0;
    start_to = 1'b1;
    step(); start_to = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("to_wait_valid", 32'(to_mem_valid), 32'd1);
      chk("to_wait_done", 32'(to_done), 32'd0);
      step();
    end
    chk("to_valid_drop", 32'(to_mem_valid), 32'd0);
    chk("to_done", 32'(to_done), 32'd1);
    chk("to_bus_err", 32'(to_bus_err), 32'd1);
    chk("to_rdata", to_rdata, 32'd0);
    step();
    chk("to_idle_busy", 32'(to_busy), 32'd0);

    // Reset asserted mid-BUS, access must not resume
    mem_ready = 1'b0;
    drive(1'b0, 3'b010, 32'h0000_8000, 32'h0);
    step(); start = 1'b0;
    chk("rb_valid", 32'(mem_valid), 32'd1);
    step();
    #2 resetn = 1'b0;
    #1;
    chk("rb_valid_async", 32'(mem_valid), 32'd0);
    chk("rb_busy_async", 32'(busy), 32'd0);
    chk("rb_done_async", 32'(done), 32'd0);
    step();
    resetn = 1'b1;
    mem_ready = 1'b1;
    step(); step(); step(); step();
    chk("rb_post_busy", 32'(busy), 32'd0);
    chk("rb_post_valid", 32'(mem_valid), 32'd0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
